uart_byte_tx: RTL

UART_BYTE_TX -- requirements
Module: uart_byte_tx

---
 rtl/uart_byte_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter with a small FIFO: 8N1 frames, LSB first, idle high.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_byte_tx #(
  parameter int CYCLES_PER_BIT = 868,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       uart_tx_out,
  output logic       busy_out
);
  localparam int TW = $clog2(CYCLES_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [7:0]      head;
  logic            push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // Ready depends only on registered count, so a pop never frees a slot in the same cycle.
  assign ready_out   = (count_q != C_FULL);
  assign push        = valid_in && ready_out;
  assign head        = mem[rd_ptr];
  assign bit_end     = (tmr_q == T_LAST);
  assign uart_tx_out = tx_q;
  assign busy_out    = (state_q != IDLE) || (count_q != '0);

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // tx_d is the line value for the state being entered, keeping the output a plain flop.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        tx_d  = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          sh_d    = head;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          tmr_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tmr_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          tmr_d = '0;
          if (count_q != '0) begin
            // Chain straight into the next start bit so frames stay contiguous.
            pop     = 1'b1;
            sh_d    = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end
endmodule
